// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FPU iterative units (multiplier and divider).
// Provides field widths, the canonical quiet NaN, operand classification and unpacking.
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

  // Special-case outcome decided once at operand capture.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } fp_special_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    fp_class_e         cls;
  } fp_unpacked_t;

  // Denormals (exp == 0, frac != 0) classify as zero so they flush.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
    fp_unpacked_t u;
    u.sign = v[31];
    u.exp  = v[30:23];
    u.frac = v[22:0];
    if (u.exp == 8'd0) begin
      u.cls = FP_ZERO;
    end else if (u.exp == 8'hFF) begin
      u.cls = (u.frac == 23'd0) ? FP_INF : FP_NAN;
    end else begin
      u.cls = FP_NORMAL;
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_mul_mant.sv
// Iterative 24x24 shift-add significand multiplier: one multiplier bit per cycle, LSB first.
// A start pulse loads operands; done pulses for one cycle when the product is complete.
module fp_mul_mant #(
  parameter int MANT_STEPS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic        done,
  output logic [47:0] product
);

  localparam int                CNT_W = $clog2(MANT_STEPS + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(MANT_STEPS - 1);

  logic [47:0]      acc_q, acc_d;
  logic [47:0]      mcand_q, mcand_d;
  logic [23:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state for one shift-add step.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = 48'd0;
      mcand_d  = {24'd0, mcand};
      mplier_d = mplier;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = {mcand_q[46:0], 1'b0};
      mplier_d = {1'b0, mplier_q[23:1]};
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= 48'd0;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative binary32 multiplier, fixed 26-cycle accept-to-valid latency, valid/ready both sides.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int MANT_STEPS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;
  fp_special_e special_q, special_d;
  logic [31:0] result_q, result_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  fp_unpacked_t ua, ub;
  fp_special_e  special_in;
  logic         accept;
  logic         mant_done;
  logic [47:0]  product;
  logic [47:0]  norm;
  logic         round_up;
  logic [24:0]  sig_r;
  logic [9:0]   exp_f;
  logic [31:0]  norm_res;

  assign ua     = fp_unpack(operand_a);
  assign ub     = fp_unpack(operand_b);
  assign accept = in_valid && in_ready_q;

  fp_mul_mant #(.MANT_STEPS(MANT_STEPS)) u_mant (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .mcand   ({1'b1, ua.frac}),
    .mplier  ({1'b1, ub.frac}),
    .done    (mant_done),
    .product (product)
  );

  // Special-case priority: NaN or 0*Inf, then Inf, then zero.
  always_comb begin
    if ((ua.cls == FP_NAN) || (ub.cls == FP_NAN) ||
        ((ua.cls == FP_ZERO) && (ub.cls == FP_INF)) ||
        ((ua.cls == FP_INF) && (ub.cls == FP_ZERO))) begin
      special_in = SP_NAN;
    end else if ((ua.cls == FP_INF) || (ub.cls == FP_INF)) begin
      special_in = SP_INF;
    end else if ((ua.cls == FP_ZERO) || (ub.cls == FP_ZERO)) begin
      special_in = SP_ZERO;
    end else begin
      special_in = SP_NONE;
    end
  end

  // Normalise so the leading one sits at bit 47, round, then clamp the range.
  always_comb begin
    norm = product[47] ? product : {product[46:0], 1'b0};
`ifdef FP_MUL_ROUND_EN
    round_up = norm[23] & ((|norm[22:0]) | norm[24]);
`else
    round_up = 1'b0;
`endif
    sig_r = {2'b01, norm[46:24]} + {24'd0, round_up};
    exp_f = exp_q + {9'd0, product[47]} + {9'd0, sig_r[24]};
    case (special_q)
      SP_NAN:  norm_res = QNAN;
      SP_INF:  norm_res = {sign_q, 8'hFF, 23'd0};
      SP_ZERO: norm_res = {sign_q, 31'd0};
      default: begin
        if ($signed(exp_f) >= 10'sd255) begin
          norm_res = {sign_q, 8'hFF, 23'd0};
        end else if ($signed(exp_f) < 10'sd1) begin
          norm_res = {sign_q, 31'd0};
        end else begin
          norm_res = {sign_q, exp_f[7:0], sig_r[22:0]};
        end
      end
    endcase
  end

`ifndef FP_MUL_ROUND_EN
  logic discard_unused;
  assign discard_unused = ^norm[23:0];
`endif

  // Sequencer next-state: capture, wait on the mantissa unit, normalise, hold until taken.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    special_d   = special_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_MUL;
          in_ready_d = 1'b0;
          sign_d     = ua.sign ^ ub.sign;
          exp_d      = {2'b00, ua.exp} + {2'b00, ub.exp} - 10'(EXP_BIAS);
          special_d  = special_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mant_done) begin
          state_d = S_NORM;
        end else begin
          state_d = S_MUL;
        end
      end
      S_NORM: begin
        result_d    = norm_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 10'd0;
      special_q   <= SP_NONE;
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      special_q   <= special_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed binary32 vectors against an arithmetic model,
// with per-cycle handshake/latency checks. Honours FP_MUL_ROUND_EN like the design.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lit;
    bit          has_lit;
  } op_t;

  op_t         q[$];
  logic [31:0] cur_lit = 32'd0;
  bit          cur_has_lit = 1'b0;
  bit          busy = 1'b0;
  int          acc_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fp_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Arithmetic model: exact integer product of the significands, then IEEE rules.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    bit     na, nb, ia, ib, za, zb;
    longint ma, mb, p, mant;
    int     sh;
    logic [7:0] e8;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (za && ib) || (ia && zb)) return 32'h7FC0_0000;
    if (ia || ib) return {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h0000_8000_0000_0000) begin
      e  = e + 1;
      sh = 24;
    end else begin
      sh = 23;
    end
    mant = p >> sh;
`ifdef FP_MUL_ROUND_EN
    begin
      longint rem, half;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 64'd1;
      if (mant == 64'h0000_0000_0100_0000) begin
        mant = mant >> 1;
        e    = e + 1;
      end
    end
`endif
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e < 1) return {s, 31'd0};
    e8 = e[7:0];
    return {s, e8, mant[22:0]};
  endfunction

  // Single compare process: handshake, latency, hold and result checks every cycle.
  initial begin
    bit          stalled;
    logic [31:0] held;
    bit          exp_ov;
    op_t         o;
    logic [31:0] m;
    stalled = 1'b0;
    held    = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        busy    = 1'b0;
        stalled = 1'b0;
      end else begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
        exp_ov = busy && ((cyc - acc_cyc) >= 27);
        chk("out_valid_timing", {31'd0, out_valid}, {31'd0, exp_ov});
        if (stalled) chk("result_hold", result, held);
        if (out_valid && busy) begin
          if (out_ready) begin
            o = q.pop_front();
            m = ref_mul(o.a, o.b);
            chk($sformatf("result %h*%h", o.a, o.b), result, m);
            if (o.has_lit) chk($sformatf("model_pin %h*%h", o.a, o.b), m, o.lit);
            busy    = 1'b0;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = result;
          end
        end else begin
          stalled = 1'b0;
        end
        if (in_valid && in_ready && !busy) begin
          q.push_back('{operand_a, operand_b, cur_lit, cur_has_lit});
          busy    = 1'b1;
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!busy) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input bit has_lit, input int stall);
    int n;
    cur_lit     = lit;
    cur_has_lit = has_lit;
    out_ready   = (stall == 0);
    operand_a   = a;
    operand_b   = b;
    in_valid    = 1'b1;
    wait_accept();
    if (stall > 0) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
      repeat (stall) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd_lit;
`ifdef FP_MUL_ROUND_EN
    rnd_lit = 32'h4010_0002;
`else
    rnd_lit = 32'h4010_0001;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_result", result, 32'd0);
    @(posedge clk);
    #1;

    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1, 0);
    run_op(32'h3FC0_0001, 32'h3FC0_0001, rnd_lit, 1'b1, 0);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 0);
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1, 0);
    run_op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b1, 0);
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 0);
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1, 0);
    run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b1, 0);
    run_op(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 0);
    run_op(32'hBFC0_0000, 32'h4020_0000, 32'hC070_0000, 1'b1, 0);
    run_op(32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b1, 10);
    for (int i = 0; i < 4; i++) begin
      run_op({1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)},
             {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)},
             32'd0, 1'b0, 0);
    end

    cur_has_lit = 1'b0;
    operand_a   = 32'h4000_0000;
    operand_b   = 32'h4040_0000;
    in_valid    = 1'b1;
    wait_accept();
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    @(posedge clk);
    #1;
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
